hilo_acc_reg: RTL and testbench
===============================

# hilo_acc_reg

Parametrised HI/LO special-register unit for the EX/WB boundary of the MIPS32 pipeline. It holds the HI and LO result registers with independent per-half writes, a clear operation, and a two-cycle multiply-accumulate path (MADD/MSUB) that adds or subtracts a 2×WIDTH product into {HI,LO}. A valid/ready handshake stalls the issuing stage while an accumulate is in flight. Optional write-forwarding outputs remove the one-cycle read-after-write bubble.

## Interface
- WIDTH, 32, width of each of HI and LO in bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  operation request
- op_ready  out  1  unit can accept an op this cycle
- op_mode  in  3  000 NOP, 001 WR_HI, 010 WR_LO, 011 WR_BOTH, 100 MADD, 101 MSUB, 110 CLEAR, 111 reserved (acts as NOP)
- hi_i  in  WIDTH  write data for HI
- lo_i  in  WIDTH  write data for LO
- prod_i  in  2*WIDTH  product operand for MADD/MSUB
- hi_o  out  WIDTH  registered HI
- lo_o  out  WIDTH  registered LO
- hi_fwd_o  out  WIDTH  HI as seen by a same-cycle reader (see Configuration)
- lo_fwd_o  out  WIDTH  LO as seen by a same-cycle reader
- busy_o  out  1  accumulate in flight
- acc_done_o  out  1  one-cycle pulse after an accumulate commits HI

## Operation
- Accept = op_valid && op_ready. Ops presented while op_ready=0 are ignored, not queued.
- State machine: IDLE, ACC_LO, ACC_HI. op_ready = (state==IDLE); busy_o = (state!=IDLE).
- IDLE, accepted WR_HI/WR_LO/WR_BOTH: the selected half or halves load from hi_i/lo_i. The other half holds.
- IDLE, accepted CLEAR: HI=LO=0.
- IDLE, accepted NOP/reserved: no change.
- IDLE, accepted MADD/MSUB: capture prod_i and direction into internal registers. Next state is ACC_LO.
- ACC_LO: LO ← LO ± prod[WIDTH-1:0]. Register the carry (add) or borrow (sub) out of bit WIDTH-1. Next state is ACC_HI.
- ACC_HI: HI ← HI ± prod[2W-1:WIDTH] ± carry/borrow. Next state is IDLE. Set acc_done_o for the following cycle.
- Arithmetic is modulo 2^(2·WIDTH). There is no saturation or overflow flag; the carry out of HI is discarded.
- Reset mid-accumulate aborts the operation: state returns to IDLE, HI=LO=0, captured product discarded, and acc_done_o is not pulsed.

## Timing
- Reset values: hi_o=0, lo_o=0, hi_fwd_o=0, lo_fwd_o=0, busy_o=0, acc_done_o=0. op_ready=1 in the cycle after reset deasserts.
- Write and CLEAR ops: accepted in cycle T, visible on hi_o/lo_o in T+1.
- MADD/MSUB accepted in cycle T:
  - T+1: ACC_LO, op_ready=0.
  - T+2: new LO visible; ACC_HI, op_ready=0.
  - T+3: new HI visible, acc_done_o=1, op_ready=1.
- Throughput: one write op per cycle, one accumulate per 3 cycles.
- Back-to-back accumulates: the second accumulate uses the fully committed {HI,LO} of the first.

## Configuration
- HILO_BYPASS_EN defined:
  - In IDLE with an accepted write op, hi_fwd_o/lo_fwd_o show the incoming value for the selected half(s) combinationally in the same cycle.
  - Accepted CLEAR forwards 0.
  - Otherwise hi_fwd_o/lo_fwd_o equal hi_o/lo_o.
  - Accumulate results are never forwarded early.
- HILO_BYPASS_EN undefined: hi_fwd_o=hi_o and lo_fwd_o=lo_o at all times; the forwarding mux is not synthesised.

## Test plan
- Reset, then WR_BOTH hi_i=0x12345678, lo_i=0x9ABCDEF0 → next cycle hi_o=0x12345678, lo_o=0x9ABCDEF0. Then WR_LO lo_i=0x1 → lo_o=0x1 and hi_o unchanged.
- {HI,LO}={0,0xFFFFFFFF}, MADD prod_i=1:
  - T+2: lo_o=0.
  - T+3: hi_o=1, acc_done_o=1 for exactly one cycle.
  - op_ready=0 in T+1 and T+2.
- {HI,LO}=0, MSUB prod_i=1 → T+3: hi_o=lo_o=0xFFFFFFFF, confirming modulo wrap.
- MADD accepted, then op_valid held high with WR_HI in T+1 and T+2 → both ignored. Re-present WR_HI 0xA5A5A5A5 in T+3 → accepted, hi_o=0xA5A5A5A5 in T+4.
- MADD accepted, rst asserted in T+2 → T+3: hi_o=lo_o=0, busy_o=0, acc_done_o=0.
- WR_HI hi_i=0xDEADBEEF in IDLE:
  - With HILO_BYPASS_EN: hi_fwd_o=0xDEADBEEF in the same cycle.
  - Without HILO_BYPASS_EN: hi_fwd_o keeps its old value until the next cycle.

Source files
------------

// File: rtl/hilo_acc_reg.sv
// HI/LO special-register unit: per-half writes, clear, and a two-cycle MADD/MSUB path.
// Define HILO_BYPASS_EN to forward accepted write data onto hi_fwd_o/lo_fwd_o in the same cycle.
module hilo_acc_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_mode,
  input  logic [WIDTH-1:0]   hi_i,
  input  logic [WIDTH-1:0]   lo_i,
  input  logic [2*WIDTH-1:0] prod_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic [WIDTH-1:0]   hi_fwd_o,
  output logic [WIDTH-1:0]   lo_fwd_o,
  output logic               busy_o,
  output logic               acc_done_o
);

  localparam logic [2:0] OpWrHi   = 3'b001;
  localparam logic [2:0] OpWrLo   = 3'b010;
  localparam logic [2:0] OpWrBoth = 3'b011;
  localparam logic [2:0] OpMadd   = 3'b100;
  localparam logic [2:0] OpMsub   = 3'b101;
  localparam logic [2:0] OpClear  = 3'b110;

  typedef enum logic [1:0] {StIdle, StAccLo, StAccHi} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               sub_q;
  logic               carry_q;
  logic               done_q;

  logic               accept;
  logic [WIDTH:0]     lo_sum;
  logic [WIDTH-1:0]   hi_sum;
  logic [WIDTH-1:0]   carry_ext;

  assign op_ready   = (state_q == StIdle);
  assign busy_o     = (state_q != StIdle);
  assign accept     = op_valid && op_ready;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign acc_done_o = done_q;

  // Bit WIDTH of the widened LO result is the carry (add) or borrow (sub) into HI.
  always_comb begin
    lo_sum    = '0;
    hi_sum    = '0;
    carry_ext = {{(WIDTH-1){1'b0}}, carry_q};
    if (sub_q) begin
      lo_sum = {1'b0, lo_q} - {1'b0, prod_q[WIDTH-1:0]};
      hi_sum = hi_q - prod_q[2*WIDTH-1:WIDTH] - carry_ext;
    end else begin
      lo_sum = {1'b0, lo_q} + {1'b0, prod_q[WIDTH-1:0]};
      hi_sum = hi_q + prod_q[2*WIDTH-1:WIDTH] + carry_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            case (op_mode)
              OpWrHi:   hi_q <= hi_i;
              OpWrLo:   lo_q <= lo_i;
              OpWrBoth: begin
                hi_q <= hi_i;
                lo_q <= lo_i;
              end
              OpMadd, OpMsub: begin
                prod_q  <= prod_i;
                sub_q   <= (op_mode == OpMsub);
                state_q <= StAccLo;
              end
              OpClear: begin
                hi_q <= '0;
                lo_q <= '0;
              end
              default: ;
            endcase
          end
        end
        StAccLo: begin
          lo_q    <= lo_sum[WIDTH-1:0];
          carry_q <= lo_sum[WIDTH];
          state_q <= StAccHi;
        end
        StAccHi: begin
          hi_q    <= hi_sum;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  // accept implies StIdle, so accumulate results never reach this mux early.
  always_comb begin
    hi_fwd_o = hi_q;
    lo_fwd_o = lo_q;
    if (accept) begin
      case (op_mode)
        OpWrHi:   hi_fwd_o = hi_i;
        OpWrLo:   lo_fwd_o = lo_i;
        OpWrBoth: begin
          hi_fwd_o = hi_i;
          lo_fwd_o = lo_i;
        end
        OpClear: begin
          hi_fwd_o = '0;
          lo_fwd_o = '0;
        end
        default: ;
      endcase
    end
  end
`else
  assign hi_fwd_o = hi_q;
  assign lo_fwd_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Directed bench for hilo_acc_reg: reference {HI,LO} model feeding a scoreboard queue.
// Honours HILO_BYPASS_EN for the forwarding checks.
module tb_hilo_acc_reg;
  localparam int unsigned W = 32;
`ifdef HILO_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           op_valid;
  logic           op_ready;
  logic [2:0]     op_mode;
  logic [W-1:0]   hi_i;
  logic [W-1:0]   lo_i;
  logic [2*W-1:0] prod_i;
  logic [W-1:0]   hi_o;
  logic [W-1:0]   lo_o;
  logic [W-1:0]   hi_fwd_o;
  logic [W-1:0]   lo_fwd_o;
  logic           busy_o;
  logic           acc_done_o;

  hilo_acc_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_mode    (op_mode),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .prod_i     (prod_i),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .hi_fwd_o   (hi_fwd_o),
    .lo_fwd_o   (lo_fwd_o),
    .busy_o     (busy_o),
    .acc_done_o (acc_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.hi  = hi_m;
    e.lo  = lo_m;
    sb.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_hi"}, 64'(hi_o), 64'(e.hi));
      chk({e.tag, "_lo"}, 64'(lo_o), 64'(e.lo));
    end
  endtask

  task automatic drive(input logic [2:0] mode, input logic [W-1:0] h, input logic [W-1:0] l,
                       input logic [2*W-1:0] p);
    op_valid = 1'b1;
    op_mode  = mode;
    hi_i     = h;
    lo_i     = l;
    prod_i   = p;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
    op_mode  = 3'b000;
  endtask

  task automatic model_wr(input logic [2:0] mode, input logic [W-1:0] h, input logic [W-1:0] l);
    case (mode)
      3'b001: hi_m = h;
      3'b010: lo_m = l;
      3'b011: begin hi_m = h; lo_m = l; end
      3'b110: begin hi_m = '0; lo_m = '0; end
      default: ;
    endcase
  endtask

  task automatic wr_op(input logic [2:0] mode, input logic [W-1:0] h, input logic [W-1:0] l,
                       input string tag);
    drive(mode, h, l, '0);
    model_wr(mode, h, l);
    push_exp(tag);
    tick();
    idle_in();
    pop_chk();
  endtask

  // Returns in cycle T+3 with inputs idle; the caller may issue the next op immediately.
  task automatic acc_op(input logic sub, input logic [2*W-1:0] p, input string tag);
    logic [2*W-1:0] r;
    drive(sub ? 3'b101 : 3'b100, '0, '0, p);
    r = sub ? ({hi_m, lo_m} - p) : ({hi_m, lo_m} + p);
    tick();
    idle_in();
    chk({tag, "_rdy_t1"}, 64'(op_ready), 64'd0);
    chk({tag, "_busy_t1"}, 64'(busy_o), 64'd1);
    tick();
    chk({tag, "_lo_t2"}, 64'(lo_o), 64'(r[W-1:0]));
    chk({tag, "_rdy_t2"}, 64'(op_ready), 64'd0);
    hi_m = r[2*W-1:W];
    lo_m = r[W-1:0];
    push_exp(tag);
    tick();
    chk({tag, "_done_t3"}, 64'(acc_done_o), 64'd1);
    chk({tag, "_rdy_t3"}, 64'(op_ready), 64'd1);
    pop_chk();
  endtask

  initial begin
    logic [2*W-1:0] p;
    rst = 1'b1;
    idle_in();
    hi_i   = '0;
    lo_i   = '0;
    prod_i = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    chk("rst_hifwd", 64'(hi_fwd_o), 64'd0);
    chk("rst_lofwd", 64'(lo_fwd_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(acc_done_o), 64'd0);
    chk("rst_ready", 64'(op_ready), 64'd1);

    wr_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, "wr_both");
    wr_op(3'b010, 32'hFFFF_0000, 32'h0000_0001, "wr_lo");
    wr_op(3'b000, 32'h5555_5555, 32'h6666_6666, "nop");
    wr_op(3'b111, 32'h7777_7777, 32'h8888_8888, "reserved");

    // Carry from LO into HI, then acc_done must drop after one cycle.
    wr_op(3'b011, 32'h0, 32'hFFFF_FFFF, "setup_carry");
    acc_op(1'b0, 64'd1, "madd_carry");
    tick();
    chk("madd_done_t4", 64'(acc_done_o), 64'd0);

    wr_op(3'b110, '0, '0, "clear");
    acc_op(1'b1, 64'd1, "msub_wrap");
    chk("msub_wrap_val", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back accumulates with random operands.
    wr_op(3'b011, $urandom(), $urandom(), "setup_b2b");
    p = {$urandom(), $urandom()};
    acc_op(1'b0, p, "b2b_madd");
    p = {$urandom(), $urandom()};
    acc_op(1'b1, p, "b2b_msub");
    acc_op(1'b1, 64'h0000_0001_8000_0001, "b2b_msub2");
    tick();

    // Ops held during an accumulate must be ignored, then accepted once idle.
    drive(3'b100, '0, '0, 64'h0000_0002_0000_0003);
    p = {hi_m, lo_m} + 64'h0000_0002_0000_0003;
    tick();
    drive(3'b001, 32'h1111_1111, '0, '0);
    chk("ign_rdy_t1", 64'(op_ready), 64'd0);
    tick();
    chk("ign_rdy_t2", 64'(op_ready), 64'd0);
    tick();
    hi_m = p[2*W-1:W];
    lo_m = p[W-1:0];
    push_exp("ign_acc");
    pop_chk();
    drive(3'b001, 32'hA5A5_A5A5, '0, '0);
    model_wr(3'b001, 32'hA5A5_A5A5, '0);
    push_exp("ign_wrhi");
    tick();
    idle_in();
    pop_chk();

    // Reset in T+2 aborts the accumulate.
    drive(3'b100, '0, '0, 64'h0123_4567_89AB_CDEF);
    tick();
    idle_in();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    chk("abort_hi", 64'(hi_o), 64'd0);
    chk("abort_lo", 64'(lo_o), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(acc_done_o), 64'd0);
    tick();
    chk("abort_done_t4", 64'(acc_done_o), 64'd0);
    chk("abort_hi_t4", 64'(hi_o), 64'd0);

    // Same-cycle forwarding of a write.
    wr_op(3'b011, 32'h0BAD_F00D, 32'h0000_1234, "pre_fwd");
    drive(3'b001, 32'hDEAD_BEEF, 32'hCAFE_CAFE, '0);
    #1;
    chk("fwd_hi_same", 64'(hi_fwd_o), Byp ? 64'hDEAD_BEEF : 64'(hi_m));
    chk("fwd_lo_same", 64'(lo_fwd_o), 64'(lo_m));
    model_wr(3'b001, 32'hDEAD_BEEF, 32'hCAFE_CAFE);
    push_exp("fwd_wrhi");
    tick();
    idle_in();
    pop_chk();
    chk("fwd_hi_next", 64'(hi_fwd_o), 64'hDEAD_BEEF);
    drive(3'b110, '0, '0, '0);
    #1;
    chk("fwd_clr_same", {hi_fwd_o, lo_fwd_o}, Byp ? 64'd0 : {hi_m, lo_m});
    model_wr(3'b110, '0, '0);
    push_exp("fwd_clear");
    tick();
    idle_in();
    pop_chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
